cache_req_arbiter: RTL and testbench
====================================

CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

Interface
REQ-001 Parameter W, default 64, address width in bits.
REQ-002 Parameter B, default 64, cache line size in bytes; line width is B*8.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset; synchronous and active-high.
REQ-005 req_valid_in  input  [1:0]  per-requester request valid (index 0, 1).
REQ-006 req_ready_out  output  [1:0]  per-requester accept pulse.
REQ-007 req_addr_in  input  2 x W  per-requester request address.
REQ-008 req_we_in  input  [1:0]  per-requester write (eviction) flag.
REQ-009 req_line_in  input  2 x B*8  per-requester write line data.
REQ-010 lc_valid_out / lc_ready_in  output / input  1 / 1  downstream request handshake.
REQ-011 lc_addr_out, lc_value_out, we_out  output  W, B*8, 1  downstream request fields.
REQ-012 lc_valid_in / lc_ready_out  input / output  1 / 1  downstream response handshake.
REQ-013 lc_addr_in, lc_value_in  input  W, B*8  downstream response address and line.
REQ-014 rsp_valid_out / rsp_ready_in  output / input  [1:0] / [1:0]  per-requester response handshake.
REQ-015 rsp_addr_out, rsp_line_out  output  W, B*8  shared response fields, qualified by rsp_valid_out.
REQ-016 busy_out, grant_id_out, err_out  output  1, 1, 1  transaction in flight; owner index; address-mismatch pulse.

Function
REQ-017 The block SHALL arbitrate two requesters onto one lower-level cache port, with exactly one transaction in flight.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_RESP, RETURN.
REQ-019 IDLE SHALL grant when any req_valid_in bit is 1, as follows.
- Single valid requester: grant that requester.
- Both valid: grant the index opposite last_grant (round-robin).
REQ-020 On grant, the block SHALL pulse req_ready_out[grant] for exactly one cycle.
REQ-021 On grant, the block SHALL latch the granted addr, we and line; set owner and last_grant to the granted index; and move to ISSUE the next cycle.
REQ-022 Latched addresses SHALL have the low log2(B) bits forced to 0 for read requests; write addresses SHALL pass unchanged.
REQ-023 ISSUE SHALL drive lc_valid_out=1, lc_addr_out, lc_value_out (line for writes, 0 for reads) and we_out from latched values, held stable until lc_ready_in=1.
REQ-024 On an ISSUE cycle with lc_ready_in=1, the block SHALL go to IDLE for a write and to WAIT_RESP for a read.
REQ-025 WAIT_RESP SHALL drive lc_ready_out=1.
REQ-026 In WAIT_RESP, lc_valid_in=1 with a block-aligned lc_addr_in equal to the latched address SHALL capture lc_value_in and move to RETURN.
REQ-027 In WAIT_RESP, lc_valid_in=1 with a mismatched address SHALL pulse err_out for one cycle, discard the data, and remain in WAIT_RESP.
REQ-028 RETURN SHALL assert only rsp_valid_out[owner], with rsp_addr_out and rsp_line_out stable, until rsp_ready_in[owner]=1, then go to IDLE.
REQ-029 In RETURN, rsp_ready_in of the non-owner SHALL be ignored.
REQ-030 In IDLE, lc_ready_out SHALL be 0, and a stray lc_valid_in SHALL pulse err_out.
REQ-031 busy_out SHALL be 1 in every state except IDLE; grant_id_out SHALL equal owner.
REQ-032 Minimum latencies SHALL be:
- Read: grant to rsp_valid_out = 3 cycles with zero-wait downstream.
- Write: grant back to IDLE = 2 cycles.
REQ-033 A requester SHALL NOT be re-granted in the IDLE cycle immediately after its own completion if the other requester is valid.

Reset
REQ-034 While rst_in=1 at a clock edge, the block SHALL enter IDLE, and every output (including lc_value_out, rsp_line_out, rsp_addr_out and lc_addr_out) SHALL be 0.
REQ-035 While rst_in=1 at a clock edge, last_grant SHALL be set to 1 so requester 0 wins the first contention, and owner SHALL be set to 0.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction with no response issued; a late lc_valid_in after reset SHALL be handled per REQ-030.

Verification
REQ-037 Single read: req_valid_in=01, addr 0x1040 -> req_ready_out[0] pulse; lc_addr_out=0x1040, we_out=0; response line L at 0x1040 -> rsp_valid_out=01, rsp_line_out=L.
REQ-038 Contention: both valid every cycle, two reads each -> grant order 0,1,0,1 and each response routed only to its owner.
REQ-039 Write: req_we_in[1]=1, addr 0x2000, line D, lc_ready_in low 3 cycles -> lc_valid_out and fields held stable 4 cycles, then IDLE with no rsp_valid_out.
REQ-040 Mismatch: in WAIT_RESP (addr 0x1040), inject response at 0x3000 -> err_out pulse, state held; then correct response -> normal return.
REQ-041 Backpressure and reset: rsp_ready_in=00 for 5 cycles in RETURN -> rsp_valid_out held.
- rst_in=1 for 1 cycle during WAIT_RESP -> all outputs 0, IDLE, next contention grants requester 0.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: shares one lower-level cache port between two requesters.
// Only one transaction is in flight at a time. Reads wait for a matching line
// response and return it to their owner. Writes (evictions) complete as soon
// as the downstream port accepts them.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A valid side holds its fields stable until that edge. req_ready_out
// is the exception: it is a one-cycle accept pulse, and the requester drops
// valid (or presents its next request) after seeing it.
module cache_req_arbiter #(
   parameter int W = 64,
   parameter int B = 64
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [1:0]           req_valid_in,
   output logic [1:0]           req_ready_out,
   input  logic [1:0][W-1:0]    req_addr_in,
   input  logic [1:0]           req_we_in,
   input  logic [1:0][B*8-1:0]  req_line_in,
   output logic                 lc_valid_out,
   input  logic                 lc_ready_in,
   output logic [W-1:0]         lc_addr_out,
   output logic [B*8-1:0]       lc_value_out,
   output logic                 we_out,
   input  logic                 lc_valid_in,
   output logic                 lc_ready_out,
   input  logic [W-1:0]         lc_addr_in,
   input  logic [B*8-1:0]       lc_value_in,
   output logic [1:0]           rsp_valid_out,
   input  logic [1:0]           rsp_ready_in,
   output logic [W-1:0]         rsp_addr_out,
   output logic [B*8-1:0]       rsp_line_out,
   output logic                 busy_out,
   output logic                 grant_id_out,
   output logic                 err_out,
   output logic [1:0]           state_out
);

   localparam int            LW       = B * 8;
   localparam logic [W-1:0]  OFS_MASK = W'(B - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      RETURN    = 2'd3
   } state_t;

   state_t         state_q;
   logic           last_grant_q;
   logic           owner_q;
   logic           we_q;
   logic           lc_valid_q;
   logic           err_q;
   logic [1:0]     req_ready_q;
   logic [1:0]     rsp_valid_q;
   logic [W-1:0]   lc_addr_q;
   logic [W-1:0]   rsp_addr_q;
   logic [LW-1:0]  lc_value_q;
   logic [LW-1:0]  rsp_line_q;

   logic           gnt_id_d;
   logic [W-1:0]   gnt_addr_d;

   // Pick the winner: a lone requester wins, otherwise alternate away from last_grant.
   always_comb begin
      gnt_id_d = ~last_grant_q;
      if (req_valid_in == 2'b01) begin
         gnt_id_d = 1'b0;
      end else if (req_valid_in == 2'b10) begin
         gnt_id_d = 1'b1;
      end
      gnt_addr_d = req_addr_in[gnt_id_d];
      if (!req_we_in[gnt_id_d]) begin
         gnt_addr_d = gnt_addr_d & ~OFS_MASK;
      end
   end

   // Transaction FSM with all handshake outputs registered.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         lc_valid_q   <= 1'b0;
         err_q        <= 1'b0;
         req_ready_q  <= 2'b00;
         rsp_valid_q  <= 2'b00;
         lc_addr_q    <= '0;
         rsp_addr_q   <= '0;
         lc_value_q   <= '0;
         rsp_line_q   <= '0;
      end else begin
         req_ready_q <= 2'b00;
         err_q       <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // No request is outstanding, so any response here is stray.
               if (lc_valid_in) begin
                  err_q <= 1'b1;
               end
               if (|req_valid_in) begin
                  req_ready_q[gnt_id_d] <= 1'b1;
                  owner_q      <= gnt_id_d;
                  last_grant_q <= gnt_id_d;
                  we_q         <= req_we_in[gnt_id_d];
                  lc_addr_q    <= gnt_addr_d;
                  lc_value_q   <= req_we_in[gnt_id_d] ? req_line_in[gnt_id_d] : '0;
                  lc_valid_q   <= 1'b1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               if (lc_ready_in) begin
                  lc_valid_q <= 1'b0;
                  state_q    <= we_q ? IDLE : WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (lc_valid_in) begin
                  // The latched read address is already aligned, so equality also demands alignment.
                  if (lc_addr_in == lc_addr_q) begin
                     rsp_line_q           <= lc_value_in;
                     rsp_addr_q           <= lc_addr_q;
                     rsp_valid_q[owner_q] <= 1'b1;
                     state_q              <= RETURN;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            RETURN: begin
               if (rsp_ready_in[owner_q]) begin
                  rsp_valid_q <= 2'b00;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_out = req_ready_q;
   assign lc_valid_out  = lc_valid_q;
   assign lc_addr_out   = lc_addr_q;
   assign lc_value_out  = lc_value_q;
   assign we_out        = we_q;
   assign lc_ready_out  = (state_q == WAIT_RESP);
   assign rsp_valid_out = rsp_valid_q;
   assign rsp_addr_out  = rsp_addr_q;
   assign rsp_line_out  = rsp_line_q;
   assign busy_out      = (state_q != IDLE);
   assign grant_id_out  = owner_q;
   assign err_out       = err_q;
   assign state_out     = state_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: directed scenarios followed by randomized transactions,
// each checked against a transaction-level model of the arbiter.
`define CK(t, o, e) chk(t, LW'(o), LW'(e))

module tb_cache_req_arbiter;

  localparam int W  = 64;
  localparam int B  = 64;
  localparam int LW = B * 8;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic [1:0]           req_valid_in;
  logic [1:0]           req_ready_out;
  logic [1:0][W-1:0]    req_addr_in;
  logic [1:0]           req_we_in;
  logic [1:0][LW-1:0]   req_line_in;
  logic                 lc_valid_out;
  logic                 lc_ready_in;
  logic [W-1:0]         lc_addr_out;
  logic [LW-1:0]        lc_value_out;
  logic                 we_out;
  logic                 lc_valid_in;
  logic                 lc_ready_out;
  logic [W-1:0]         lc_addr_in;
  logic [LW-1:0]        lc_value_in;
  logic [1:0]           rsp_valid_out;
  logic [1:0]           rsp_ready_in;
  logic [W-1:0]         rsp_addr_out;
  logic [LW-1:0]        rsp_line_out;
  logic                 busy_out;
  logic                 grant_id_out;
  logic                 err_out;
  logic [1:0]           state_out;

  int n_cmp = 0;
  int n_err = 0;
  bit model_last;

  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] sb_exp;

  cache_req_arbiter #(.W(W), .B(B)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_addr_in   (req_addr_in),
    .req_we_in     (req_we_in),
    .req_line_in   (req_line_in),
    .lc_valid_out  (lc_valid_out),
    .lc_ready_in   (lc_ready_in),
    .lc_addr_out   (lc_addr_out),
    .lc_value_out  (lc_value_out),
    .we_out        (we_out),
    .lc_valid_in   (lc_valid_in),
    .lc_ready_out  (lc_ready_out),
    .lc_addr_in    (lc_addr_in),
    .lc_value_in   (lc_value_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_ready_in  (rsp_ready_in),
    .rsp_addr_out  (rsp_addr_out),
    .rsp_line_out  (rsp_line_out),
    .busy_out      (busy_out),
    .grant_id_out  (grant_id_out),
    .err_out       (err_out),
    .state_out     (state_out)
  );

  // Clock.
  always #5 clk_in = ~clk_in;

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: every completed response handshake must deliver the next expected line.
  always @(posedge clk_in) begin
    if (!rst_in && ((rsp_valid_out & rsp_ready_in) != 2'b00)) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL sb: response handshake with empty expected queue");
      end else begin
        sb_exp = exp_q.pop_front();
        n_cmp++;
        if (rsp_line_out !== sb_exp) begin
          n_err++;
          $error("FAIL sb_line observed=%0h expected=%0h", rsp_line_out, sb_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int id);
    logic [1:0] r;
    r = 2'b00;
    r[id[0]] = 1'b1;
    return r;
  endfunction

  // Reference arbitration rule: a lone requester wins, a tie goes opposite the last grant.
  function automatic int pick(input logic [1:0] mask);
    if (mask == 2'b01) return 0;
    if (mask == 2'b10) return 1;
    return model_last ? 0 : 1;
  endfunction

  // Reads are issued at the start of their cache line; writes go out as given.
  function automatic logic [W-1:0] expect_addr(input logic [W-1:0] addr, input logic we);
    logic [W-1:0] bsz;
    bsz = W'(B);
    return we ? addr : (addr / bsz) * bsz;
  endfunction

  function automatic logic [W-1:0] rand_addr();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Grant happens on the edge after requests appear in IDLE; accept pulse goes to the winner.
  task automatic grant(output int id);
    id = pick(req_valid_in);
    step();
    `CK("grant_pulse", req_ready_out, onehot(id));
    model_last = id[0];
  endtask

  task automatic chk_all_zero(input string tag);
    `CK({tag, "_req_ready"}, req_ready_out, 2'b00);
    `CK({tag, "_lc_valid"}, lc_valid_out, 1'b0);
    `CK({tag, "_lc_addr"}, lc_addr_out, 64'h0);
    `CK({tag, "_lc_value"}, lc_value_out, 512'h0);
    `CK({tag, "_we"}, we_out, 1'b0);
    `CK({tag, "_lc_ready"}, lc_ready_out, 1'b0);
    `CK({tag, "_rsp_valid"}, rsp_valid_out, 2'b00);
    `CK({tag, "_rsp_addr"}, rsp_addr_out, 64'h0);
    `CK({tag, "_rsp_line"}, rsp_line_out, 512'h0);
    `CK({tag, "_busy"}, busy_out, 1'b0);
    `CK({tag, "_grant_id"}, grant_id_out, 1'b0);
    `CK({tag, "_err"}, err_out, 1'b0);
  endtask

  // Drives the downstream side of one granted transaction and checks it to completion.
  task automatic serve(input int id, input logic [W-1:0] a, input logic we,
                       input logic [LW-1:0] val, input int lc_wait, input bit mm,
                       input logic [W-1:0] mm_addr, input int delay, input int bp,
                       input logic [LW-1:0] rline);
    logic [1:0] oh;
    oh = onehot(id);
    `CK("issue_busy", busy_out, 1'b1);
    `CK("issue_grant_id", grant_id_out, id[0]);
    `CK("issue_lc_valid", lc_valid_out, 1'b1);
    `CK("issue_lc_addr", lc_addr_out, a);
    `CK("issue_lc_value", lc_value_out, val);
    `CK("issue_we", we_out, we);
    for (int i = 0; i < lc_wait; i++) begin
      step();
      `CK("hold_req_ready", req_ready_out, 2'b00);
      `CK("hold_lc_valid", lc_valid_out, 1'b1);
      `CK("hold_lc_addr", lc_addr_out, a);
      `CK("hold_lc_value", lc_value_out, val);
      `CK("hold_we", we_out, we);
    end
    lc_ready_in = 1'b1;
    step();
    lc_ready_in = 1'b0;
    `CK("post_issue_req_ready", req_ready_out, 2'b00);
    `CK("post_issue_lc_valid", lc_valid_out, 1'b0);
    if (we) begin
      `CK("write_done_busy", busy_out, 1'b0);
      `CK("write_no_rsp", rsp_valid_out, 2'b00);
      `CK("write_lc_ready", lc_ready_out, 1'b0);
    end else begin
      `CK("wait_busy", busy_out, 1'b1);
      `CK("wait_lc_ready", lc_ready_out, 1'b1);
      if (mm) begin
        lc_addr_in  = mm_addr;
        lc_value_in = ~rline;
        lc_valid_in = 1'b1;
        step();
        lc_valid_in = 1'b0;
        `CK("mm_err", err_out, 1'b1);
        `CK("mm_no_rsp", rsp_valid_out, 2'b00);
        `CK("mm_still_waiting", lc_ready_out, 1'b1);
        step();
        `CK("mm_err_pulse", err_out, 1'b0);
        `CK("mm_still_waiting2", lc_ready_out, 1'b1);
      end
      for (int i = 0; i < delay; i++) step();
      exp_q.push_back(rline);
      lc_addr_in  = a;
      lc_value_in = rline;
      lc_valid_in = 1'b1;
      step();
      lc_valid_in = 1'b0;
      `CK("rsp_valid", rsp_valid_out, oh);
      `CK("rsp_addr", rsp_addr_out, a);
      `CK("rsp_line", rsp_line_out, rline);
      `CK("rsp_err", err_out, 1'b0);
      `CK("rsp_lc_ready", lc_ready_out, 1'b0);
      for (int i = 0; i < bp; i++) begin
        rsp_ready_in = (i % 2 == 0) ? 2'b00 : ~oh;
        step();
        `CK("bp_rsp_valid", rsp_valid_out, oh);
        `CK("bp_rsp_addr", rsp_addr_out, a);
        `CK("bp_rsp_line", rsp_line_out, rline);
      end
      rsp_ready_in = oh;
      step();
      rsp_ready_in = 2'b00;
      `CK("ret_done_rsp_valid", rsp_valid_out, 2'b00);
      `CK("ret_done_busy", busy_out, 1'b0);
    end
  endtask

  initial begin : main
    int id;
    int cnt [2];
    logic [1:0] mask;
    logic [W-1:0] a;
    logic [LW-1:0] val;
    logic [LW-1:0] line_l;

    rst_in       = 1'b1;
    req_valid_in = 2'b00;
    req_addr_in  = '0;
    req_we_in    = 2'b00;
    req_line_in  = '0;
    lc_ready_in  = 1'b0;
    lc_valid_in  = 1'b0;
    lc_addr_in   = '0;
    lc_value_in  = '0;
    rsp_ready_in = 2'b00;
    model_last   = 1'b1;

    // Reset state.
    step();
    step();
    chk_all_zero("reset");
    rst_in = 1'b0;

    // Stray response while idle.
    lc_addr_in  = 64'h1040;
    lc_valid_in = 1'b1;
    step();
    lc_valid_in = 1'b0;
    `CK("stray_err", err_out, 1'b1);
    `CK("stray_idle", busy_out, 1'b0);
    `CK("stray_lc_ready", lc_ready_out, 1'b0);
    step();
    `CK("stray_err_pulse", err_out, 1'b0);

    // Single read from requester 0, zero-wait downstream.
    line_l         = rand_line();
    req_addr_in[0] = 64'h1040;
    req_we_in      = 2'b00;
    req_valid_in   = 2'b01;
    grant(id);
    req_valid_in = 2'b00;
    serve(id, 64'h1040, 1'b0, '0, 0, 1'b0, '0, 0, 0, line_l);

    // Write from requester 1 with three cycles of downstream stall.
    val            = rand_line();
    req_addr_in[1] = 64'h2000;
    req_we_in      = 2'b10;
    req_line_in[1] = val;
    req_valid_in   = 2'b10;
    grant(id);
    req_valid_in = 2'b00;
    serve(id, 64'h2000, 1'b1, val, 3, 1'b0, '0, 0, 0, '0);

    // Mismatched response address, then the correct one.
    req_addr_in[0] = 64'h1040;
    req_we_in      = 2'b00;
    req_valid_in   = 2'b01;
    grant(id);
    req_valid_in = 2'b00;
    serve(id, 64'h1040, 1'b0, '0, 0, 1'b1, 64'h3000, 1, 0, rand_line());

    // Unaligned read from requester 1 with five cycles of response backpressure.
    req_addr_in[1] = 64'h4085;
    req_valid_in   = 2'b10;
    grant(id);
    req_valid_in = 2'b00;
    serve(id, 64'h4080, 1'b0, '0, 1, 1'b0, '0, 2, 5, rand_line());

    // Reset while waiting for a read response.
    req_addr_in[0] = 64'h5000;
    req_valid_in   = 2'b01;
    grant(id);
    req_valid_in = 2'b00;
    lc_ready_in  = 1'b1;
    step();
    lc_ready_in = 1'b0;
    `CK("pre_reset_waiting", lc_ready_out, 1'b1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    model_last = 1'b1;
    chk_all_zero("mid_reset");
    lc_addr_in  = 64'h5000;
    lc_value_in = rand_line();
    lc_valid_in = 1'b1;
    step();
    lc_valid_in = 1'b0;
    `CK("late_rsp_err", err_out, 1'b1);
    `CK("late_rsp_no_rsp", rsp_valid_out, 2'b00);
    `CK("late_rsp_idle", busy_out, 1'b0);
    step();

    // Contention: both hold valid, two reads each.
    cnt[0]         = 2;
    cnt[1]         = 2;
    req_addr_in[0] = 64'h0100;
    req_addr_in[1] = 64'h0200;
    req_we_in      = 2'b00;
    req_valid_in   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      grant(id);
      a = req_addr_in[id[0]];
      cnt[id]--;
      if (cnt[id] == 0) req_valid_in[id[0]] = 1'b0;
      serve(id, a, 1'b0, '0, 0, 1'b0, '0, 0, 1, rand_line());
    end
    req_valid_in = 2'b00;

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      mask = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        req_addr_in[r] = rand_addr();
        req_we_in[r]   = 1'($urandom_range(0, 1));
        req_line_in[r] = rand_line();
      end
      req_valid_in = mask;
      grant(id);
      req_valid_in = 2'b00;
      a   = expect_addr(req_addr_in[id[0]], req_we_in[id[0]]);
      val = req_we_in[id[0]] ? req_line_in[id[0]] : '0;
      serve(id, a, req_we_in[id[0]], val, $urandom_range(0, 3),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1) ? (a ^ 64'h40) : (a | 64'h1),
            $urandom_range(0, 2), $urandom_range(0, 3), rand_line());
    end

    step();
    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL sb: %0d expected responses never returned", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    if (n_err == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule

`undef CK
